// File: rtl/afe_arb_pkg.sv
// Shared definitions for the ADC buffer write-port arbiter.
package afe_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_NUM_ADC_DEFAULT = 4;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/afe_buf_wr_arb_if.sv
// Request/grant bundle between the adc_top instances and the buffer write arbiter.
interface afe_buf_wr_arb_if #(
    parameter int NUM_ADC = 4
);
    localparam int IW = $clog2(NUM_ADC);

    logic               en_i;
    logic               prio_mode_i;
    logic [NUM_ADC-1:0] req_i;
    logic [NUM_ADC-1:0] grant_ack_i;
    logic [NUM_ADC-1:0] grant_o;
    logic [IW-1:0]      sel_o;
    logic               busy_o;
    logic               timeout_event_o;
    logic [IW-1:0]      timeout_id_o;

    modport master (
        output en_i, prio_mode_i, req_i, grant_ack_i,
        input  grant_o, sel_o, busy_o, timeout_event_o, timeout_id_o
    );

    modport slave (
        input  en_i, prio_mode_i, req_i, grant_ack_i,
        output grant_o, sel_o, busy_o, timeout_event_o, timeout_id_o
    );

endinterface

// File: rtl/afe_rr_pick.sv
// Combinational winner search: rotating (from i_ptr, wrapping) or fixed (index 0 first).
module afe_rr_pick #(
    parameter int NUM_ADC = 4,
    parameter int IW      = $clog2(NUM_ADC)
) (
    input  logic [NUM_ADC-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_fixed,
    output logic [NUM_ADC-1:0] o_onehot,
    output logic [IW-1:0]      o_idx,
    output logic               o_valid
);

    logic [IW-1:0] w_base;
    logic [IW:0]   w_cand;

    // Walk offsets from the far end so the closest requester is written last.
    always_comb begin
        w_base   = i_fixed ? '0 : i_ptr;
        w_cand   = '0;
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int i = NUM_ADC - 1; i >= 0; i--) begin
            w_cand = {1'b0, w_base} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(NUM_ADC))
                w_cand = w_cand - (IW+1)'(NUM_ADC);
            if (i_req[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
        if (o_valid)
            o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/afe_buf_wr_arb.sv
// Arbitrates the shared capture-buffer write port among NUM_ADC adc_top instances,
// with ack-driven hand-over and a per-grant timeout.
//   state     | meaning
//   ST_IDLE   | no grant held; arbitrate when enabled and any request is up
//   ST_GRANT  | grant_o held on sel_o until ack or wait counter expiry
module afe_buf_wr_arb
    import afe_arb_pkg::*;
#(
    parameter int NUM_ADC        = ARB_NUM_ADC_DEFAULT,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    afe_buf_wr_arb_if.slave arb_if
);

    localparam int IW = $clog2(NUM_ADC);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [0:0]         ST_IDLE  = ARB_IDLE;
    localparam logic [0:0]         ST_GRANT = ARB_GRANT;
    localparam logic [NUM_ADC-1:0] ONE      = NUM_ADC'(1);

    logic [0:0]         r_state;
    logic [NUM_ADC-1:0] r_grant;
    logic [IW-1:0]      r_sel;
    logic [IW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_cnt;
    logic               r_tmo_evt;
    logic [IW-1:0]      r_tmo_id;

    logic               w_ack;
    logic [IW-1:0]      w_ptr_nxt;
    logic [NUM_ADC-1:0] w_pick_req;
    logic [IW-1:0]      w_pick_ptr;
    logic [NUM_ADC-1:0] w_onehot;
    logic [IW-1:0]      w_idx;
    logic               w_valid;
    logic [NUM_ADC-1:0] w_lower;
    logic               w_hi_prio;
    logic               w_b2b_ok;

    assign w_ack      = (r_state == ST_GRANT) && arb_if.grant_ack_i[r_sel];
    assign w_ptr_nxt  = (r_sel == IW'(NUM_ADC - 1)) ? '0 : r_sel + 1'b1;
    assign w_pick_req = (r_state == ST_GRANT) ? (arb_if.req_i & ~r_grant) : arb_if.req_i;
    assign w_pick_ptr = (r_state == ST_GRANT) ? w_ptr_nxt : r_rr_ptr;

    // In fixed mode a hand-over only happens to a higher-priority requester; otherwise
    // the releasing (highest-priority) requester gets the port back after one idle cycle.
    assign w_lower   = (ONE << r_sel) - ONE;
    assign w_hi_prio = |(arb_if.req_i & w_lower);
    assign w_b2b_ok  = arb_if.en_i && w_valid && (!arb_if.prio_mode_i || w_hi_prio);

    afe_rr_pick #(
        .NUM_ADC (NUM_ADC),
        .IW      (IW)
    ) u_pick (
        .i_req    (w_pick_req),
        .i_ptr    (w_pick_ptr),
        .i_fixed  (arb_if.prio_mode_i),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            r_tmo_evt <= 1'b0;
            r_tmo_id  <= '0;
        end else begin
            r_tmo_evt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arb_if.en_i && w_valid) begin
                        r_grant <= w_onehot;
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                default: begin
                    if (w_ack) begin
                        r_rr_ptr <= w_ptr_nxt;
                        if (w_b2b_ok) begin
                            r_grant <= w_onehot;
                            r_sel   <= w_idx;
                            r_cnt   <= '0;
                        end else begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_grant   <= '0;
                        r_tmo_evt <= 1'b1;
                        r_tmo_id  <= r_sel;
                        r_rr_ptr  <= w_ptr_nxt;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign arb_if.grant_o         = r_grant;
    assign arb_if.sel_o           = r_sel;
    assign arb_if.busy_o          = (r_state == ST_GRANT);
    assign arb_if.timeout_event_o = r_tmo_evt;
    assign arb_if.timeout_id_o    = r_tmo_id;

endmodule

// File: tb/tb_afe_buf_wr_arb.sv
// Directed bench for afe_buf_wr_arb: stimulus pushes expected grants/timeouts to a
// queue, a negedge monitor pops and compares as the DUT presents them.
module tb_afe_buf_wr_arb;

    localparam int N = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    afe_buf_wr_arb_if #(.NUM_ADC(N)) arb_if ();

    afe_buf_wr_arb #(
        .NUM_ADC        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (arb_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int mon_e;
    logic [N-1:0] prev_grant = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Acknowledge whatever is currently granted for one cycle, updating req_i alongside.
    task automatic ack_now(input logic [N-1:0] new_req);
        arb_if.grant_ack_i = arb_if.grant_o;
        arb_if.req_i       = new_req;
        tick();
        arb_if.grant_ack_i = '0;
    endtask

    // Timeouts are queued as 100+id, grants as the plain index.
    always @(negedge clk) begin
        if (arb_if.timeout_event_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_timeout: got id %0d expected none", arb_if.timeout_id_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("timeout_id", 100 + int'(arb_if.timeout_id_o), mon_e);
            end
        end
        if (arb_if.grant_o != '0 && arb_if.grant_o != prev_grant) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_grant: got grant %b expected none", arb_if.grant_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_sel", int'(arb_if.sel_o), mon_e);
                check("grant_onehot", int'(arb_if.grant_o), 1 << mon_e);
            end
        end
        prev_grant <= arb_if.grant_o;
    end

    initial begin
        arb_if.en_i        = 1'b0;
        arb_if.prio_mode_i = 1'b0;
        arb_if.req_i       = '0;
        arb_if.grant_ack_i = '0;
        #1 rst = 1'b1;
        tick(2);
        check("rst_grant", int'(arb_if.grant_o), 0);
        check("rst_sel", int'(arb_if.sel_o), 0);
        check("rst_busy", int'(arb_if.busy_o), 0);
        check("rst_tmo_evt", int'(arb_if.timeout_event_o), 0);
        check("rst_tmo_id", int'(arb_if.timeout_id_o), 0);
        rst = 1'b0;
        tick();

        // Round-robin, all requesting, ack every grant: 0,1,2,3,0 back-to-back
        arb_if.en_i  = 1'b1;
        arb_if.req_i = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        check("a_pre_busy", int'(arb_if.busy_o), 0);
        tick();
        check("a_latency", int'(arb_if.grant_o), 1);
        for (int i = 0; i < 5; i++) begin
            check("a_b2b_busy", int'(arb_if.busy_o), 1);
            ack_now((i == 4) ? 4'b0000 : 4'b1111);
        end
        check("a_end_grant", int'(arb_if.grant_o), 0);
        check("a_end_busy", int'(arb_if.busy_o), 0);
        check("a_end_sel", int'(arb_if.sel_o), 0);

        // Fixed priority, 1110 held: grant 1 each time with one idle cycle between
        arb_if.prio_mode_i = 1'b1;
        arb_if.req_i       = 4'b1110;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
        tick();
        check("b_first", int'(arb_if.grant_o), 2);
        for (int r = 0; r < 3; r++) begin
            ack_now((r == 2) ? 4'b0000 : 4'b1110);
            check("b_idle_grant", int'(arb_if.grant_o), 0);
            check("b_idle_busy", int'(arb_if.busy_o), 0);
            if (r < 2) begin
                tick();
                check("b_regrant", int'(arb_if.grant_o), 2);
            end
        end

        // Timeout on requester 2 (rr_ptr now 2), then rotation to 3
        arb_if.prio_mode_i = 1'b0;
        arb_if.req_i       = 4'b0100;
        exp_q.push_back(2); exp_q.push_back(102); exp_q.push_back(3);
        tick();
        check("c_grant", int'(arb_if.grant_o), 4);
        arb_if.req_i = 4'b1111;
        for (int k = 1; k < T; k++) begin
            tick();
            check("c_hold", int'(arb_if.grant_o), 4);
        end
        tick();
        check("c_drop", int'(arb_if.grant_o), 0);
        check("c_tmo_evt", int'(arb_if.timeout_event_o), 1);
        check("c_tmo_id", int'(arb_if.timeout_id_o), 2);
        check("c_busy", int'(arb_if.busy_o), 0);
        tick();
        check("c_tmo_pulse_end", int'(arb_if.timeout_event_o), 0);
        check("c_next_grant", int'(arb_if.grant_o), 8);
        ack_now(4'b0000);
        check("c_idle", int'(arb_if.grant_o), 0);

        // Ack on the last wait cycle wins over timeout; hand-over to 3
        arb_if.req_i = 4'b0010;
        exp_q.push_back(1); exp_q.push_back(3);
        tick();
        check("d_grant", int'(arb_if.grant_o), 2);
        arb_if.req_i = 4'b1010;
        tick(T - 1);
        check("d_last_cycle", int'(arb_if.grant_o), 2);
        ack_now(4'b1010);
        check("d_b2b", int'(arb_if.grant_o), 8);
        check("d_no_tmo", int'(arb_if.timeout_event_o), 0);
        check("d_busy", int'(arb_if.busy_o), 1);
        check("d_tmo_id_held", int'(arb_if.timeout_id_o), 2);
        ack_now(4'b0000);

        // en_i falls mid-grant: grant held until ack, then nothing while disabled
        arb_if.req_i = 4'b0010;
        exp_q.push_back(1);
        tick();
        check("e_grant", int'(arb_if.grant_o), 2);
        arb_if.en_i  = 1'b0;
        arb_if.req_i = 4'b1111;
        tick(3);
        check("e_held", int'(arb_if.grant_o), 2);
        check("e_held_busy", int'(arb_if.busy_o), 1);
        ack_now(4'b1111);
        check("e_released", int'(arb_if.grant_o), 0);
        tick(5);
        check("e_blocked", int'(arb_if.grant_o), 0);
        check("e_blocked_busy", int'(arb_if.busy_o), 0);

        // Async reset mid-grant, then single requester 3
        arb_if.en_i = 1'b1;
        exp_q.push_back(2);
        tick();
        check("f_grant", int'(arb_if.grant_o), 4);
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("f_async_grant", int'(arb_if.grant_o), 0);
        check("f_async_busy", int'(arb_if.busy_o), 0);
        check("f_async_sel", int'(arb_if.sel_o), 0);
        check("f_async_tmo_id", int'(arb_if.timeout_id_o), 0);
        tick(2);
        check("f_rst_no_tmo", int'(arb_if.timeout_event_o), 0);
        arb_if.req_i = 4'b1000;
        rst = 1'b0;
        exp_q.push_back(3);
        tick();
        check("f_post_rst_grant", int'(arb_if.grant_o), 8);
        ack_now(4'b0000);
        tick(2);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/afe_buf_wr_arb.md
AFE_BUF_WR_ARB -- requirements
Module: afe_buf_wr_arb

Interface
REQ-001 SHALL have parameter NUM_ADC, default 4: number of adc_top instances sharing one buffer write port (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles a grant may stay unacknowledged (2..255).
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en_i, input, 1: arbiter enable.
REQ-006 SHALL have port prio_mode_i, input, 1: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 SHALL have port req_i, input, NUM_ADC: per-ADC write request, i.e. the synchronized rx valid from each adc_top.
REQ-008 SHALL have port grant_ack_i, input, NUM_ADC: per-ADC write-grant acknowledge, one-cycle pulse.
REQ-009 SHALL have port grant_o, input side of adc_grant, output, NUM_ADC: one-hot or zero.
REQ-010 SHALL have port sel_o, output, $clog2(NUM_ADC): binary index of the granted ADC, used as the buffer data mux select.
REQ-011 SHALL have port busy_o, output, 1: high while in state GRANT.
REQ-012 SHALL have port timeout_event_o, output, 1: one-cycle pulse when a grant expires.
REQ-013 SHALL have port timeout_id_o, output, $clog2(NUM_ADC): index of the expired requester, held until the next timeout.

Function
REQ-014 SHALL implement two states, IDLE and GRANT.
REQ-015 In IDLE, when en_i=1 and any req_i bit is set, SHALL select a winner, register grant_o/sel_o, and enter GRANT at the next edge: one-cycle request-to-grant latency.
REQ-016 Round-robin SHALL search from pointer rr_ptr upward with wrap-around; fixed mode SHALL ignore rr_ptr.
REQ-017 In GRANT, grant_o SHALL stay constant until grant_ack_i[sel_o] or timeout; req_i changes SHALL NOT alter it.
REQ-018 On grant_ack_i[sel_o]=1, rr_ptr SHALL become (sel_o+1) mod NUM_ADC, and if en_i=1 and any req_i bit (other than the ack'ing one) is set, SHALL re-arbitrate with the updated pointer and grant at the same edge (back-to-back, no idle cycle); otherwise grant_o=0 and go to IDLE.
REQ-019 A requester's own req_i SHALL be masked in the back-to-back decision of REQ-018; it may win again only after one IDLE or another grant.
REQ-020 grant_ack_i bits other than sel_o, and any ack in IDLE, SHALL be ignored.
REQ-021 A wait counter SHALL clear on entering GRANT and increment each GRANT cycle; when it reaches TIMEOUT_CYCLES-1 without ack, SHALL drop grant_o, pulse timeout_event_o, load timeout_id_o=sel_o, advance rr_ptr as for ack, and return to IDLE.
REQ-022 Ack arriving on the timeout cycle SHALL be treated as ack; no timeout_event_o.
REQ-023 en_i=0 SHALL NOT abort an active grant; it SHALL only block new grants.
REQ-024 grant_o SHALL never have more than one bit set; sel_o SHALL equal the last granted index while busy_o=0.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); rr_ptr width SHALL be $clog2(NUM_ADC) with explicit wrap for non-power-of-two NUM_ADC.

Reset
REQ-026 On rst_i=1: state=IDLE, grant_o=0, sel_o=0, rr_ptr=0, wait counter=0, busy_o=0, timeout_event_o=0, timeout_id_o=0, asynchronously.
REQ-027 Reset mid-grant SHALL drop grant_o immediately, with no timeout pulse.

Structure
REQ-028 Shared package afe_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_GRANT) and the default TIMEOUT_CYCLES constant.
REQ-029 A sub-module afe_rr_pick (request vector + pointer + mode -> one-hot winner + index + valid) SHALL contain the combinational winner search.

Verification
REQ-030 Bench SHALL cover: req_i=4'b1111, ack on every grant -> grant order 0,1,2,3,0, back-to-back, no idle cycle.
REQ-031 Bench SHALL cover: prio_mode_i=1, req_i=4'b1110 held -> grant to 1 repeatedly, with one IDLE cycle between grants.
REQ-032 Bench SHALL cover: grant to 2, no ack for 16 cycles -> grant_o=0 at cycle 16, timeout_event_o pulse, timeout_id_o=2, next grant to 3.
REQ-033 Bench SHALL cover: ack on cycle 15 of the wait (TIMEOUT_CYCLES-1) -> no timeout, normal rotation.
REQ-034 Bench SHALL cover: en_i falls during a grant to 1 -> grant held until ack, then IDLE, and no grant while en_i=0 despite req_i=4'b1111.
REQ-035 Bench SHALL cover: rst_i asserted mid-grant -> grant_o=0 asynchronously; after release with req_i=4'b1000 -> grant to 3 one cycle later.
